pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central hazard/stall sequencer for the 5-stage RISC-V pipeline; sits beside the ID stage.
//  Merges load-use hazards, ID jumps, EX taken branches and a multi-cycle data-memory handshake.
//  Drives per-stage write enables, bubble and flush controls, plus a memory-timeout error.
//  Replaces the ad-hoc Stall/IFWrite generation with one prioritised FSM.
// PARAMETERS
//  WAIT_MAX   16  max consecutive cycles in MWAIT before timeout (1..255)
//  CNT_W      32  perf counter width (used only with PIPE_PERF_EN)
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      synchronous, active-high
//  MemRead_ex     in   1      EX-stage instruction is a load
//  rdAddr_ex      in   5      EX-stage destination register
//  rs1Addr_id     in   5      ID-stage source 1
//  rs2Addr_id     in   5      ID-stage source 2
//  Jump_id        in   1      ID-stage jal/jalr redirect
//  BranchTaken_ex in   1      EX-stage branch resolved taken
//  dmem_req       in   1      MEM-stage load/store active
//  dmem_ready     in   1      data memory completes access this cycle
//  PCWrite        out  1      PC register enable
//  IFWrite        out  1      IF/ID register enable
//  IDEXWrite      out  1      ID/EX register enable
//  EXMEMWrite     out  1      EX/MEM register enable
//  Stall          out  1      insert bubble into ID/EX (zero control bits)
//  IF_flush       out  1      zero IF/ID instruction (NOP)
//  MEMWB_bubble   out  1      write bubble into MEM/WB
//  mem_err        out  1      sticky memory-timeout flag
//  stall_cnt/flush_cnt/mwait_cnt out CNT_W each  perf counters
// BEHAVIOUR
//  States: RUN, MWAIT, ERR (2-bit). Reset -> RUN, wait_cnt=0, mem_err=0, counters=0.
//  During reset all enables=1, Stall/IF_flush/MEMWB_bubble=0.
//  Outputs are combinational from state+inputs; mem_err is registered.
//  Priority per cycle, highest first:
//   1 memwait = dmem_req & ~dmem_ready: all four enables=0, MEMWB_bubble=1, Stall=0, IF_flush=0.
//   2 BranchTaken_ex: enables=1, IF_flush=1, Stall=1 (kills IF and ID instructions).
//   3 load-use = MemRead_ex & rdAddr_ex!=0 & (rdAddr_ex==rs1Addr_id | ==rs2Addr_id):
//     PCWrite=0, IFWrite=0, Stall=1; exactly one bubble.
//   4 Jump_id: enables=1, IF_flush=1.
//   5 none: enables=1, all bubbles/flushes 0.
//  Branch and load-use together: branch wins and the load-use stall is dropped.
//  Jump and load-use together: the load-use stall applies and the jump is re-evaluated next cycle.
//  A branch or jump during memwait is held frozen in its stage; the redirect applies on the release cycle.
//  RUN -> MWAIT on memwait; wait_cnt=1.
//  MWAIT: dmem_ready -> RUN, wait_cnt=0; else wait_cnt++.
//  In MWAIT, when wait_cnt==WAIT_MAX and ~dmem_ready -> ERR, mem_err<=1.
//  dmem_ready in the same cycle as the first request: no state change, zero stall cycles.
//  ERR: all enables=0, MEMWB_bubble=1; held until reset. Only reset clears mem_err.
//  Reset asserted mid-MWAIT aborts the wait and returns to RUN next edge.
//  wait_cnt is 8 bits; it never wraps because it is bounded by WAIT_MAX.
// CONFIGURATION
//  PIPE_PERF_EN defined: per-cycle increments, wrap at 2^CNT_W.
//   stall_cnt counts load-use bubbles; flush_cnt counts IF_flush cycles; mwait_cnt counts memwait/ERR cycles.
//  PIPE_PERF_EN undefined: no counter flops; the three outputs are tied to 0.
// STRUCTURE
//  pipe_ctrl_defs.vh holds shared constants: S_RUN=0, S_MWAIT=1, S_ERR=2, and REG_X0=5'd0.
//  One sub-module, load_use_detect: combinational compare that outputs hazard.
//  Instantiate it once here; the FSM, priority mux and counters live in pipeline_ctrl.
// TESTING
//  T1 MemRead_ex=1, rdAddr_ex=5, rs1Addr_id=5 for 1 cycle
//     -> PCWrite=0, IFWrite=0, Stall=1 for one cycle; stall_cnt=1.
//  T2 MemRead_ex=1, rdAddr_ex=0, rs2Addr_id=0 -> no stall; all enables=1.
//  T3 BranchTaken_ex=1 with a simultaneous load-use
//     -> IF_flush=1, Stall=1, PCWrite=1; stall_cnt unchanged; flush_cnt+1.
//  T4 dmem_req=1 with dmem_ready low for 3 cycles, then high
//     -> 3 frozen cycles, MEMWB_bubble=1 on each, state MWAIT, then RUN; mwait_cnt=3.
//  T5 WAIT_MAX=4, dmem_ready held low
//     -> ERR entered after the 4th wait cycle; mem_err=1 and stays 1.
//     Reset pulse -> mem_err=0, state RUN.
//  T6 Jump_id=1 during memwait, released on cycle 2
//     -> no flush while frozen; IF_flush=1 on the release cycle.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl_pkg
// Brief  : Shared state encoding and constants for the pipeline hazard sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_MWAIT = 2'd1,
        S_ERR   = 2'd2
    } pipe_state_t;

    localparam logic [4:0] REG_X0     = 5'd0;
    localparam int         WAIT_CNT_W = 8;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module : load_use_detect
// Brief  : Flags an ID-stage source that reads the destination of an EX-stage load.
// Rev    : 1.0  initial release
// ============================================================================
module load_use_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic       MemRead_ex,
    input  logic [4:0] rdAddr_ex,
    input  logic [4:0] rs1Addr_id,
    input  logic [4:0] rs2Addr_id,
    output logic       hazard
);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency
    assign hazard = MemRead_ex && (rdAddr_ex != REG_X0) &&
                    ((rdAddr_ex == rs1Addr_id) || (rdAddr_ex == rs2Addr_id));

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module : pipeline_ctrl
// Brief  : Prioritised stall/flush sequencer with data-memory wait timeout.
//          Optional perf counters enabled by defining PIPE_PERF_EN.
// Rev    : 1.0  initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MemRead_ex,
    input  logic [4:0]       rdAddr_ex,
    input  logic [4:0]       rs1Addr_id,
    input  logic [4:0]       rs2Addr_id,
    input  logic             Jump_id,
    input  logic             BranchTaken_ex,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IFWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             Stall,
    output logic             IF_flush,
    output logic             MEMWB_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] mwait_cnt
);

    localparam logic [WAIT_CNT_W-1:0] c_wait_max = WAIT_CNT_W'(WAIT_MAX);

    pipe_state_t           r_state,    w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic                  r_mem_err,  w_mem_err_nxt;
    logic                  w_memwait;
    logic                  w_hazard;

    load_use_detect u_load_use_detect (
        .MemRead_ex (MemRead_ex),
        .rdAddr_ex  (rdAddr_ex),
        .rs1Addr_id (rs1Addr_id),
        .rs2Addr_id (rs2Addr_id),
        .hazard     (w_hazard)
    );

    assign w_memwait = dmem_req && !dmem_ready;
    assign mem_err   = r_mem_err;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_mem_err  <= w_mem_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_mem_err_nxt  = r_mem_err;
        PCWrite        = 1'b1;
        IFWrite        = 1'b1;
        IDEXWrite      = 1'b1;
        EXMEMWrite     = 1'b1;
        Stall          = 1'b0;
        IF_flush       = 1'b0;
        MEMWB_bubble   = 1'b0;

        case (r_state)
            S_RUN: begin
                if (w_memwait) begin
                    w_state_nxt    = S_MWAIT;
                    w_wait_cnt_nxt = WAIT_CNT_W'(1);
                end
            end
            S_MWAIT: begin
                if (dmem_ready) begin
                    w_state_nxt    = S_RUN;
                    w_wait_cnt_nxt = '0;
                end else if (r_wait_cnt == c_wait_max) begin
                    w_state_nxt   = S_ERR;
                    w_mem_err_nxt = 1'b1;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + WAIT_CNT_W'(1);
                end
            end
            S_ERR: ;
            default: begin
                w_state_nxt    = S_RUN;
                w_wait_cnt_nxt = '0;
            end
        endcase

        // Reset forces the free-running defaults; otherwise strict priority order
        if (!reset) begin
            if (r_state == S_ERR || w_memwait) begin
                PCWrite      = 1'b0;
                IFWrite      = 1'b0;
                IDEXWrite    = 1'b0;
                EXMEMWrite   = 1'b0;
                MEMWB_bubble = 1'b1;
            end else if (BranchTaken_ex) begin
                IF_flush = 1'b1;
                Stall    = 1'b1;
            end else if (w_hazard) begin
                PCWrite = 1'b0;
                IFWrite = 1'b0;
                Stall   = 1'b1;
            end else if (Jump_id) begin
                IF_flush = 1'b1;
            end
        end
    end

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt, r_mwait_cnt;

    // Stall with PC held is unique to the load-use case (a branch keeps PC enabled)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
            r_mwait_cnt <= '0;
        end else begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(Stall && !PCWrite);
            r_flush_cnt <= r_flush_cnt + CNT_W'(IF_flush);
            r_mwait_cnt <= r_mwait_cnt + CNT_W'(MEMWB_bubble);
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign mwait_cnt = r_mwait_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign mwait_cnt = '0;
`endif

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_pipeline_ctrl
// Brief  : Directed scoreboard bench for pipeline_ctrl (WAIT_MAX=4).
// Rev    : 1.0  initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int CNT_W = 32;

    // {PCWrite,IFWrite,IDEXWrite,EXMEMWrite,Stall,IF_flush,MEMWB_bubble,mem_err}
    localparam logic [7:0] RUNV = 8'b1111_0000;
    localparam logic [7:0] LU   = 8'b0011_1000;
    localparam logic [7:0] BR   = 8'b1111_1100;
    localparam logic [7:0] JMP  = 8'b1111_0100;
    localparam logic [7:0] FRZ  = 8'b0000_0010;
    localparam logic [7:0] ERRV = 8'b0000_0011;
    localparam logic [7:0] RSTE = 8'b1111_0001;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic MemRead_ex = 1'b0;
    logic [4:0] rdAddr_ex = '0, rs1Addr_id = '0, rs2Addr_id = '0;
    logic Jump_id = 1'b0, BranchTaken_ex = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic PCWrite, IFWrite, IDEXWrite, EXMEMWrite, Stall, IF_flush, MEMWB_bubble, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, mwait_cnt;

    int n_cmp = 0;
    int n_fail = 0;
    logic [7:0] exp_q[$];
    string      tag_q[$];

    pipeline_ctrl #(.WAIT_MAX(4), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .MemRead_ex     (MemRead_ex),
        .rdAddr_ex      (rdAddr_ex),
        .rs1Addr_id     (rs1Addr_id),
        .rs2Addr_id     (rs2Addr_id),
        .Jump_id        (Jump_id),
        .BranchTaken_ex (BranchTaken_ex),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .PCWrite        (PCWrite),
        .IFWrite        (IFWrite),
        .IDEXWrite      (IDEXWrite),
        .EXMEMWrite     (EXMEMWrite),
        .Stall          (Stall),
        .IF_flush       (IF_flush),
        .MEMWB_bubble   (MEMWB_bubble),
        .mem_err        (mem_err),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt),
        .mwait_cnt      (mwait_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [CNT_W-1:0] cnt_exp(input int v);
`ifdef PIPE_PERF_EN
        return CNT_W'(v);
`else
        return '0;
`endif
    endfunction

    // One clock cycle: drive inputs, queue the expected outputs, compare mid-cycle.
    task automatic step(input string tag, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic jmp,
                        input logic br, input logic req, input logic rdy,
                        input logic [7:0] exp);
        logic [7:0] e, obs;
        string t;
        MemRead_ex = mr; rdAddr_ex = rd; rs1Addr_id = rs1; rs2Addr_id = rs2;
        Jump_id = jmp; BranchTaken_ex = br; dmem_req = req; dmem_ready = rdy;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        @(negedge clk);
        obs = {PCWrite, IFWrite, IDEXWrite, EXMEMWrite, Stall, IF_flush, MEMWB_bubble, mem_err};
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %b expected <empty scoreboard>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", t, obs, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag, input logic [7:0] exp);
        step(tag, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, exp);
    endtask

    task automatic check_cnt(input string tag, input int s, input int f, input int m);
        logic [3*CNT_W-1:0] obs, e;
        obs = {stall_cnt, flush_cnt, mwait_cnt};
        e   = {cnt_exp(s), cnt_exp(f), cnt_exp(m)};
        n_cmp++;
        assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed s=%0d f=%0d m=%0d expected s=%0d f=%0d m=%0d",
                   tag, stall_cnt, flush_cnt, mwait_cnt,
                   cnt_exp(s), cnt_exp(f), cnt_exp(m));
        end
    endtask

    initial begin
        @(posedge clk); #1;
        // reset overrides a simultaneous load-use and memwait
        step("reset_defaults", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, RUNV);
        reset = 1'b0;
        idle("idle_after_reset", RUNV);
        check_cnt("cnt_reset", 0, 0, 0);

        // T1 load-use on rs1: exactly one bubble
        step("t1_loaduse_rs1", 1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, LU);
        idle("t1_release", RUNV);
        check_cnt("cnt_t1", 1, 0, 0);

        // T2 load to x0 never stalls; rs2 match does
        step("t2_x0_no_stall", 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, RUNV);
        step("t2_loaduse_rs2", 1'b1, 5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, LU);
        step("t2_no_match",    1'b1, 5'd7, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, RUNV);

        // T3 branch beats load-use
        step("t3_branch_over_lu", 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR);
        check_cnt("cnt_t3", 2, 1, 0);

        // Jump alone, then jump with load-use (stall first, jump next cycle)
        step("jump_alone", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, JMP);
        step("jump_plus_lu", 1'b1, 5'd6, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, LU);
        step("jump_retry",   1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, JMP);
        check_cnt("cnt_jump", 3, 3, 0);

        // T4 three wait cycles then ready
        for (int i = 0; i < 3; i++)
            step($sformatf("t4_frozen_%0d", i), 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ);
        step("t4_release", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, RUNV);
        check_cnt("cnt_t4", 3, 3, 3);

        // Ready with the first request: no stall; branch next cycle proceeds at once
        step("ready_same_cycle", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, RUNV);
        step("branch_after_ready", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR);

        // T6 jump held frozen during memwait, redirect on release
        step("t6_jump_frozen_0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, FRZ);
        step("t6_jump_frozen_1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, FRZ);
        step("t6_jump_release",  1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, JMP);
        step("branch_frozen",    1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ);
        step("branch_release",   1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, BR);
        check_cnt("cnt_t6", 3, 6, 6);

        // T5 timeout: entry cycle plus four wait cycles, then sticky ERR
        for (int i = 0; i < 5; i++)
            step($sformatf("t5_wait_%0d", i), 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ);
        step("t5_err_0", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, ERRV);
        step("t5_err_ready", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, ERRV);
        step("t5_err_idle", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, ERRV);
        check_cnt("cnt_t5", 3, 6, 14);

        reset = 1'b1;
        idle("t5_reset_cycle", RSTE);
        reset = 1'b0;
        idle("t5_after_reset", RUNV);
        check_cnt("cnt_after_reset", 0, 0, 0);
        step("lu_after_reset", 1'b1, 5'd12, 5'd12, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, LU);
        idle("final_idle", RUNV);
        check_cnt("cnt_final", 1, 0, 0);

        n_cmp++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_pipeline_ctrl
`default_nettype wire
